clk_period_meter: RTL and testbench
===================================

Name: clk_period_meter

Overview:
- Measurement stage directly downstream of div_half.
- Samples the divided clock (div_half clk_out) as a plain data signal in a faster reference clock domain.
- Measures the total period and high time over a window of WIN consecutive periods, then reports both with a done pulse.
- Used in bring-up and in benches to confirm divider ratio and duty without scope-level inspection.

Parameters:
- CNT_W, 16: width of period_cnt / high_cnt; counters saturate at 2^CNT_W-1.
- WIN, 8: number of sig_in periods per measurement (>=1).
- SYNC_STAGES, 2: flops in the sig_in synchronizer (>=2).
- TIMEOUT, 4095: maximum clk cycles allowed without a sig_in rising edge before the measurement aborts.

Ports:
- clk  input  1  reference clock; must be faster than 2x the sig_in frequency.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a measurement; sampled only in IDLE.
- sig_in  input  1  asynchronous signal under test (divider output).
- busy  output  1  high from the cycle after start is accepted until the cycle done is asserted.
- done  output  1  one-cycle pulse when results are valid.
- timeout  output  1  set together with done when the measurement aborted; held until the next start.
- period_cnt  output  CNT_W  clk cycles spanning WIN sig_in periods; held until the next done.
- high_cnt  output  CNT_W  clk cycles with synchronized sig_in high within the same span; held.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset state:
  - All outputs 0.
  - FSM in IDLE.
  - Synchronizer flops cleared.
- Synchronizer and edge detect:
  - sig_in passes through SYNC_STAGES flops to give sync.
  - Rising edge is detected as rise = sync & ~sync_d, where sync_d is sync delayed one cycle.
- FSM states and transitions:
  - IDLE:
    - start=1 -> ARM. On the same edge, busy<=1, timeout<=0, and the internal counters clear.
    - start while busy is ignored; there is no queueing.
  - ARM:
    - Waits for rise. On rise: period and high counters <=0, edge counter <=0, state -> MEAS.
    - If the wait counter reaches TIMEOUT with no rise: abort.
  - MEAS:
    - Every cycle: period counter +1, saturating.
    - Every cycle: high counter +1 if sync=1, saturating.
    - On rise: edge counter +1, wait counter cleared.
    - When the edge counter reaches WIN, on that rise cycle: latch the counter values including that cycle's increment -> DONE.
    - Wait counter reaches TIMEOUT between rises: abort.
  - DONE:
    - done=1 and busy<=0 for one cycle, then -> IDLE.
  - Abort:
    - period_cnt <=0, high_cnt <=0, timeout <=1, then -> DONE.
- Latency:
  - done is asserted the cycle after the WIN-th rise following the arm edge.
  - Relative to sig_in, add SYNC_STAGES+1 cycles of synchronizer and edge-detect delay.
- Saturation: both counters stop at 2^CNT_W-1 and do not wrap. The measurement still completes normally.
- Simultaneous events:
  - rise on the same cycle the wait counter hits TIMEOUT: rise wins, no abort.
  - start in the DONE cycle: ignored.
- Reset mid-operation: immediate return to IDLE; all outputs 0, including previously latched results.
- Constant sig_in (stuck at 0 or 1): produces no rise, so the measurement aborts via timeout.

Optional Feature:
- Macro: CLK_PERIOD_METER_DUTY_EN.
- Defined: the high counter and high_cnt behave as described above.
- Undefined: the high counter logic is removed, and high_cnt is tied to 0. Port list unchanged.

Test Plan:
- Nominal: sig_in periodic, 5 cycles high / 4 cycles low. WIN=8, start pulse -> done once, period_cnt=72, high_cnt=40, timeout=0, busy deasserted on the done cycle.
- Stuck signal: sig_in held 1, TIMEOUT=100, start -> done about 101 cycles after ARM entry, timeout=1, period_cnt=0, high_cnt=0.
- Start while busy: second start issued mid-MEAS -> ignored; exactly one done, results identical to the nominal case.
- Saturation: CNT_W=6, nominal 9-cycle stimulus -> period_cnt=63, high_cnt=40, timeout=0.
- Reset mid-measure: drop rst_n during MEAS -> all outputs 0 immediately. After release, a new start gives period_cnt=72, high_cnt=40.
- Macro off: nominal stimulus with CLK_PERIOD_METER_DUTY_EN undefined -> period_cnt=72, high_cnt=0.

Source files
------------

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period and high time of a slow signal
// (typically a divided clock) over WIN consecutive periods, sampled in the
// faster clk domain. Results are reported with a one-cycle done pulse.
//
// Optional feature macro: CLK_PERIOD_METER_DUTY_EN
//   defined   -> high-time counter is built and high_cnt reports it
//   undefined -> high-time logic is removed and high_cnt is tied to zero
module clk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int WIN         = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4095
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sig_in,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt
);

    localparam int EDGE_W = $clog2(WIN + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(WIN - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } state_t;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    state_t                 state_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_d_r;
    logic [CNT_W-1:0]       per_r;
    logic [EDGE_W-1:0]      edge_r;
    logic [WAIT_W-1:0]      wait_r;

    logic                   sync_s;
    logic                   rise_s;
    logic                   wait_hit_s;
    logic [CNT_W-1:0]       per_nxt_s;

    // sig_in is asynchronous: bring it through a plain flop chain, then
    // keep one more delayed copy for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r   <= {SYNC_STAGES{1'b0}};
            sync_d_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], sig_in};
            sync_d_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Edge detect and next-count values shared by the FSM and the high counter.
    always_comb begin
        sync_s     = sync_r[SYNC_STAGES-1];
        rise_s     = sync_s & ~sync_d_r;
        wait_hit_s = (wait_r == WAIT_MAX);
        per_nxt_s  = sat_inc(per_r);
    end

    // Measurement FSM: arm on start, count over WIN periods, latch or abort.
    // A rise always beats a simultaneous timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            period_cnt <= {CNT_W{1'b0}};
            per_r      <= {CNT_W{1'b0}};
            edge_r     <= {EDGE_W{1'b0}};
            wait_r     <= {WAIT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r <= ARM;
                        busy    <= 1'b1;
                        timeout <= 1'b0;
                        per_r   <= {CNT_W{1'b0}};
                        edge_r  <= {EDGE_W{1'b0}};
                        wait_r  <= {WAIT_W{1'b0}};
                    end
                end
                ARM: begin
                    if (rise_s) begin
                        state_r <= MEAS;
                        per_r   <= {CNT_W{1'b0}};
                        edge_r  <= {EDGE_W{1'b0}};
                        wait_r  <= {WAIT_W{1'b0}};
                    end else if (wait_hit_s) begin
                        state_r    <= DONE;
                        period_cnt <= {CNT_W{1'b0}};
                        timeout    <= 1'b1;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        wait_r <= wait_r + {{(WAIT_W-1){1'b0}}, 1'b1};
                    end
                end
                MEAS: begin
                    per_r <= per_nxt_s;
                    if (rise_s) begin
                        edge_r <= edge_r + {{(EDGE_W-1){1'b0}}, 1'b1};
                        wait_r <= {WAIT_W{1'b0}};
                        if (edge_r == LAST_EDGE) begin
                            state_r    <= DONE;
                            period_cnt <= per_nxt_s;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                        end
                    end else if (wait_hit_s) begin
                        state_r    <= DONE;
                        period_cnt <= {CNT_W{1'b0}};
                        timeout    <= 1'b1;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        wait_r <= wait_r + {{(WAIT_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLK_PERIOD_METER_DUTY_EN
    logic [CNT_W-1:0] high_r;
    logic [CNT_W-1:0] high_nxt_s;
    logic             clr_s;
    logic             latch_s;
    logic             abort_s;

    // Decode the FSM events that clear, latch or zero the high-time count.
    always_comb begin
        high_nxt_s = sync_s ? sat_inc(high_r) : high_r;
        clr_s      = ((state_r == IDLE) && start) || ((state_r == ARM) && rise_s);
        latch_s    = (state_r == MEAS) && rise_s && (edge_r == LAST_EDGE);
        abort_s    = ((state_r == ARM) || (state_r == MEAS)) && !rise_s && wait_hit_s;
    end

    // High-time counter runs alongside the period counter during MEAS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_r   <= {CNT_W{1'b0}};
            high_cnt <= {CNT_W{1'b0}};
        end else begin
            if (clr_s) begin
                high_r <= {CNT_W{1'b0}};
            end else if (state_r == MEAS) begin
                high_r <= high_nxt_s;
            end else begin
                high_r <= high_r;
            end
            if (latch_s) begin
                high_cnt <= high_nxt_s;
            end else if (abort_s) begin
                high_cnt <= {CNT_W{1'b0}};
            end else begin
                high_cnt <= high_cnt;
            end
        end
    end
`else
    assign high_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed testbench for clk_period_meter. Three instances: default
// parameters, a narrow-counter one (CNT_W=6) sharing the same stimulus,
// and a short-timeout one (TIMEOUT=100) fed a stuck-high signal.
module tb_clk_period_meter;

`ifdef CLK_PERIOD_METER_DUTY_EN
    localparam int EXP_HIGH = 40;
`else
    localparam int EXP_HIGH = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start_a;
    logic        sig_a;
    logic        start_b;
    logic        sig_b;

    logic        busy_m, done_m, to_m;
    logic [15:0] per_m, high_m;
    logic        busy_s, done_s, to_s;
    logic [5:0]  per_s, high_s;
    logic        busy_t, done_t, to_t;
    logic [15:0] per_t, high_t;

    int n_tests;
    int n_fail;
    int done_seen;
    int n;

    clk_period_meter u_main (
        .clk(clk), .rst_n(rst_n), .start(start_a), .sig_in(sig_a),
        .busy(busy_m), .done(done_m), .timeout(to_m),
        .period_cnt(per_m), .high_cnt(high_m)
    );

    clk_period_meter #(.CNT_W(6)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_a), .sig_in(sig_a),
        .busy(busy_s), .done(done_s), .timeout(to_s),
        .period_cnt(per_s), .high_cnt(high_s)
    );

    clk_period_meter #(.TIMEOUT(100)) u_to (
        .clk(clk), .rst_n(rst_n), .start(start_b), .sig_in(sig_b),
        .busy(busy_t), .done(done_t), .timeout(to_t),
        .period_cnt(per_t), .high_cnt(high_t)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 9-cycle periodic stimulus: 5 cycles high, 4 cycles low.
    initial begin
        int phase;
        phase = 0;
        sig_a = 1'b0;
        forever begin
            @(negedge clk);
            sig_a = (phase < 5);
            phase = (phase == 8) ? 0 : phase + 1;
        end
    end

    always @(negedge clk) begin
        if (done_m) done_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_m(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (done_m) break;
            @(negedge clk);
        end
        chk("done_within_bound", {31'd0, done_m}, 32'd1);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        done_seen = 0;
        rst_n     = 1'b0;
        start_a   = 1'b0;
        start_b   = 1'b0;
        sig_b     = 1'b1;

        // Reset state
        #1;
        chk("rst_busy",   {31'd0, busy_m}, 32'd0);
        chk("rst_done",   {31'd0, done_m}, 32'd0);
        chk("rst_timeout",{31'd0, to_m},   32'd0);
        chk("rst_period", {16'd0, per_m},  32'd0);
        chk("rst_high",   {16'd0, high_m}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Nominal measurement (plus saturation on the narrow instance)
        done_seen = 0;
        pulse_start_a();
        chk("busy_after_start", {31'd0, busy_m}, 32'd1);
        wait_done_m(300);
        chk("nom_busy_on_done", {31'd0, busy_m}, 32'd0);
        chk("nom_timeout",      {31'd0, to_m},   32'd0);
        chk("nom_period",       {16'd0, per_m},  32'd72);
        chk("nom_high",         {16'd0, high_m}, EXP_HIGH);
        chk("sat_done",         {31'd0, done_s}, 32'd1);
        chk("sat_period",       {26'd0, per_s},  32'd63);
        chk("sat_high",         {26'd0, high_s}, EXP_HIGH);
        chk("sat_timeout",      {31'd0, to_s},   32'd0);
        @(negedge clk);
        chk("done_one_cycle",   {31'd0, done_m}, 32'd0);
        chk("period_held",      {16'd0, per_m},  32'd72);
        repeat (5) @(negedge clk);

        // Second start during MEAS is ignored
        done_seen = 0;
        pulse_start_a();
        repeat (30) @(negedge clk);
        chk("busy_mid_meas", {31'd0, busy_m}, 32'd1);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_m(300);
        chk("rebusy_period", {16'd0, per_m},  32'd72);
        chk("rebusy_high",   {16'd0, high_m}, EXP_HIGH);
        repeat (120) @(negedge clk);
        chk("rebusy_one_done", done_seen, 32'd1);
        chk("rebusy_idle",     {31'd0, busy_m}, 32'd0);

        // Stuck-high signal aborts via timeout
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 1;
        while (!done_t && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("stuck_done",     {31'd0, done_t}, 32'd1);
        chk("stuck_latency",  n - 1,           32'd101);
        chk("stuck_timeout",  {31'd0, to_t},   32'd1);
        chk("stuck_period",   {16'd0, per_t},  32'd0);
        chk("stuck_high",     {16'd0, high_t}, 32'd0);
        chk("stuck_busy",     {31'd0, busy_t}, 32'd0);
        repeat (3) @(negedge clk);
        chk("timeout_held",   {31'd0, to_t},   32'd1);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("timeout_cleared",{31'd0, to_t},   32'd0);
        chk("rearm_busy",     {31'd0, busy_t}, 32'd1);
        repeat (110) @(negedge clk);

        // Reset in the middle of a measurement
        pulse_start_a();
        repeat (30) @(negedge clk);
        chk("mid_busy", {31'd0, busy_m}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",   {31'd0, busy_m}, 32'd0);
        chk("mid_rst_period", {16'd0, per_m},  32'd0);
        chk("mid_rst_high",   {16'd0, high_m}, 32'd0);
        chk("mid_rst_done",   {31'd0, done_m}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        pulse_start_a();
        wait_done_m(300);
        chk("post_rst_period",  {16'd0, per_m},  32'd72);
        chk("post_rst_high",    {16'd0, high_m}, EXP_HIGH);
        chk("post_rst_timeout", {31'd0, to_m},   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
